// File: rtl/bp_assoc_cache.sv
// Set-associative branch-history cache.
// Each entry holds a saturating counter for one branch PC. The entry is tagged
// by the upper address bits and indexed by the low address bits.
// Two combinational lookup ports read the current state. One update port
// trains the counter on a hit, or allocates an entry on a miss using true-LRU
// replacement. Updates take effect at the clock edge and there is no bypass.
// Handshake: upd_valid is a one-cycle request with no backpressure. Every
// cycle with upd_valid high (and reset high) is consumed at that posedge.
module bp_assoc_cache #(
   parameter int AWIDTH = 30,
   parameter int CWIDTH = 2,
   parameter int SETS   = 4,
   parameter int WAYS   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] ra0,
   output logic [CWIDTH-1:0] ctr0,
   output logic              hit0,
   output logic              taken0,
   input  logic [AWIDTH-1:0] ra1,
   output logic [CWIDTH-1:0] ctr1,
   output logic              hit1,
   output logic              taken1,
   input  logic              upd_valid,
   input  logic [AWIDTH-1:0] upd_addr,
   input  logic              upd_taken
);

   localparam int IDXW = $clog2(SETS);
   localparam int TAGW = AWIDTH - IDXW;
   localparam int AGEW = (WAYS > 1) ? $clog2(WAYS) : 1;

   localparam logic [CWIDTH-1:0] CTR_MAX = '1;
   localparam logic [CWIDTH-1:0] CTR_WT  = CWIDTH'(1) << (CWIDTH - 1);
   localparam logic [CWIDTH-1:0] CTR_WNT = CTR_WT - CWIDTH'(1);
   localparam logic [AGEW-1:0]   AGE_MAX = AGEW'(WAYS - 1);

   // Per-entry state. The ages within one set always form a permutation of 0..WAYS-1.
   logic              r_valid [SETS][WAYS];
   logic [TAGW-1:0]   r_tag   [SETS][WAYS];
   logic [CWIDTH-1:0] r_ctr   [SETS][WAYS];
   logic [AGEW-1:0]   r_age   [SETS][WAYS];

   logic [AWIDTH-1:0] w_ra  [2];
   logic              w_hit [2];
   logic [CWIDTH-1:0] w_ctr [2];

   logic [IDXW-1:0]   w_upd_idx;
   logic [TAGW-1:0]   w_upd_tag;
   logic              w_upd_hit;
   logic [AGEW-1:0]   w_hit_way;
   logic              w_has_inv;
   logic [AGEW-1:0]   w_inv_way;
   logic [AGEW-1:0]   w_lru_way;
   logic [AGEW-1:0]   w_touch_way;
   logic [AGEW-1:0]   w_old_age;

   assign w_ra[0]   = ra0;
   assign w_ra[1]   = ra1;
   assign w_upd_idx = upd_addr[IDXW-1:0];
   assign w_upd_tag = upd_addr[AWIDTH-1:IDXW];

   // Lookup ports. Allocation never creates two matching ways, so OR-ing the matches is safe.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_hit[p] = 1'b0;
         w_ctr[p] = '0;
         for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_ra[p][IDXW-1:0]][w] &&
                (r_tag[w_ra[p][IDXW-1:0]][w] == w_ra[p][AWIDTH-1:IDXW])) begin
               w_hit[p] = 1'b1;
               w_ctr[p] = r_ctr[w_ra[p][IDXW-1:0]][w];
            end
         end
      end
   end

   assign ctr0   = w_ctr[0];
   assign hit0   = w_hit[0];
   assign taken0 = w_hit[0] & w_ctr[0][CWIDTH-1];
   assign ctr1   = w_ctr[1];
   assign hit1   = w_hit[1];
   assign taken1 = w_hit[1] & w_ctr[1][CWIDTH-1];

   // Update decode: the hit way, otherwise the lowest invalid way, otherwise the oldest way.
   always_comb begin
      w_upd_hit = 1'b0;
      w_hit_way = '0;
      w_has_inv = 1'b0;
      w_inv_way = '0;
      w_lru_way = '0;
      // Scan downward so that the lowest-numbered invalid way is the last one written.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w_upd_idx][w]) begin
            w_has_inv = 1'b1;
            w_inv_way = AGEW'(w);
         end
      end
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w_upd_idx][w] && (r_tag[w_upd_idx][w] == w_upd_tag)) begin
            w_upd_hit = 1'b1;
            w_hit_way = AGEW'(w);
         end
         if (r_age[w_upd_idx][w] == AGE_MAX) begin
            w_lru_way = AGEW'(w);
         end
      end
      w_touch_way = w_upd_hit ? w_hit_way : (w_has_inv ? w_inv_way : w_lru_way);
      w_old_age   = r_age[w_upd_idx][w_touch_way];
   end

   // State update: reset takes priority, then counter training or allocation plus the LRU age shuffle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               r_valid[s][w] <= 1'b0;
               r_tag[s][w]   <= '0;
               r_ctr[s][w]   <= '0;
               r_age[s][w]   <= AGEW'(w);
            end
         end
      end else if (upd_valid) begin
         for (int w = 0; w < WAYS; w++) begin
            if (AGEW'(w) == w_touch_way) begin
               r_age[w_upd_idx][w] <= '0;
            end else if (r_age[w_upd_idx][w] < w_old_age) begin
               r_age[w_upd_idx][w] <= r_age[w_upd_idx][w] + AGEW'(1);
            end
         end
         if (w_upd_hit) begin
            if (upd_taken) begin
               if (r_ctr[w_upd_idx][w_touch_way] != CTR_MAX) begin
                  r_ctr[w_upd_idx][w_touch_way] <= r_ctr[w_upd_idx][w_touch_way] + CWIDTH'(1);
               end
            end else begin
               if (r_ctr[w_upd_idx][w_touch_way] != '0) begin
                  r_ctr[w_upd_idx][w_touch_way] <= r_ctr[w_upd_idx][w_touch_way] - CWIDTH'(1);
               end
            end
         end else begin
            r_valid[w_upd_idx][w_touch_way] <= 1'b1;
            r_tag[w_upd_idx][w_touch_way]   <= w_upd_tag;
            r_ctr[w_upd_idx][w_touch_way]   <= upd_taken ? CTR_WT : CTR_WNT;
         end
      end
   end

endmodule

// File: tb/tb_bp_assoc_cache.sv
// Directed bench for bp_assoc_cache (SETS=4, WAYS=2, CWIDTH=2).
// Each expected entry is {hit, ctr[1:0], taken} per port, and the port-0
// nibble is placed above the port-1 nibble.
module tb_bp_assoc_cache;

   localparam int AW = 30;
   localparam logic [3:0] MISS = 4'b0000;
   localparam logic [3:0] H0   = 4'b1000;  // hit, ctr 0
   localparam logic [3:0] H1   = 4'b1010;  // hit, ctr 1
   localparam logic [3:0] H2   = 4'b1101;  // hit, ctr 2, taken
   localparam logic [3:0] H3   = 4'b1111;  // hit, ctr 3, taken

   logic          clk;
   logic          reset;
   logic [AW-1:0] ra0, ra1, upd_addr;
   logic [1:0]    ctr0, ctr1;
   logic          hit0, hit1, taken0, taken1;
   logic          upd_valid, upd_taken;

   logic          chk_valid;
   logic [7:0]    exp_q[$];
   int            n_compared;
   int            n_failed;

   bp_assoc_cache #(.AWIDTH(AW), .CWIDTH(2), .SETS(4), .WAYS(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .ra0       (ra0),
      .ctr0      (ctr0),
      .hit0      (hit0),
      .taken0    (taken0),
      .ra1       (ra1),
      .ctr1      (ctr1),
      .hit1      (hit1),
      .taken1    (taken1),
      .upd_valid (upd_valid),
      .upd_addr  (upd_addr),
      .upd_taken (upd_taken)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver: drive one cycle of inputs and optionally queue the expected lookup response
   task automatic step(input logic rst_n, input logic uv, input logic [AW-1:0] ua,
                       input logic ut, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic chk, input logic [3:0] e0, input logic [3:0] e1);
      reset     = rst_n;
      upd_valid = uv;
      upd_addr  = ua;
      upd_taken = ut;
      ra0       = a0;
      ra1       = a1;
      if (chk) exp_q.push_back({e0, e1});
      chk_valid = chk;
      @(posedge clk);
      #1;
   endtask

   // Monitor: sample mid-cycle, before the posedge that applies this cycle's update
   always @(negedge clk) begin
      if (chk_valid) begin
         logic [7:0] exp_v;
         logic [3:0] act0, act1;
         act0 = {hit0, ctr0, taken0};
         act1 = {hit1, ctr1, taken1};
         if (exp_q.size() == 0) begin
            n_compared++;
            n_failed++;
            $display("FAIL scoreboard_underflow at %0t", $time);
         end else begin
            exp_v = exp_q.pop_front();
            n_compared++;
            if (act0 !== exp_v[7:4]) begin
               n_failed++;
               $display("FAIL port0 ra0=%h got {hit,ctr,taken}=%b want %b at %0t",
                        ra0, act0, exp_v[7:4], $time);
            end
            n_compared++;
            if (act1 !== exp_v[3:0]) begin
               n_failed++;
               $display("FAIL port1 ra1=%h got {hit,ctr,taken}=%b want %b at %0t",
                        ra1, act1, exp_v[3:0], $time);
            end
         end
      end
   end

   // Stimulus sequence
   initial begin
      n_compared = 0;
      n_failed   = 0;
      chk_valid  = 1'b0;
      reset      = 1'b0;
      upd_valid  = 1'b0;
      upd_addr   = '0;
      upd_taken  = 1'b0;
      ra0        = '0;
      ra1        = '0;
      @(posedge clk); #1;
      step(0, 0, 'h00, 0, 'h00, 'h00, 0, MISS, MISS);

      // Everything misses after reset
      step(1, 0, 'h00, 0, 'h10, 'h23, 1, MISS, MISS);

      // Training on 0x10: allocate weakly taken, saturate at 3, then decrement down to 0 and hold
      step(1, 1, 'h10, 1, 'h10, 'h23, 1, MISS, MISS);
      step(1, 1, 'h10, 1, 'h10, 'h23, 1, H2,   MISS);
      step(1, 1, 'h10, 1, 'h10, 'h23, 1, H3,   MISS);
      step(1, 1, 'h10, 0, 'h10, 'h23, 1, H3,   MISS);
      step(1, 1, 'h10, 0, 'h10, 'h23, 1, H2,   MISS);
      step(1, 1, 'h10, 0, 'h10, 'h23, 1, H1,   MISS);
      step(1, 1, 'h10, 0, 'h10, 'h23, 1, H0,   MISS);
      step(1, 0, 'h10, 0, 'h10, 'h23, 1, H0,   MISS);

      // Same-cycle lookup returns the pre-update value
      step(1, 1, 'h10, 1, 'h10, 'h10, 1, H0,   H0);
      step(1, 1, 'h10, 1, 'h10, 'h10, 1, H1,   H1);
      step(1, 0, 'h10, 0, 'h23, 'h10, 1, MISS, H2);

      // Fill set 0 from a clean state, then exercise LRU replacement
      step(0, 0, 'h00, 0, 'h00, 'h00, 0, MISS, MISS);
      step(1, 1, 'h04, 1, 'h04, 'h08, 1, MISS, MISS);
      step(1, 1, 'h08, 1, 'h04, 'h08, 1, H2,   MISS);
      step(1, 1, 'h04, 1, 'h04, 'h08, 1, H2,   H2);
      step(1, 1, 'h0C, 0, 'h04, 'h08, 1, H3,   H2);
      step(1, 0, 'h00, 0, 'h0C, 'h08, 1, H1,   MISS);
      step(1, 0, 'h00, 0, 'h04, 'h0C, 1, H3,   H1);

      // Set 1 fill and eviction leave set 0 alone
      step(1, 1, 'h05, 1, 'h05, 'h04, 1, MISS, H3);
      step(1, 1, 'h09, 1, 'h05, 'h09, 1, H2,   MISS);
      step(1, 1, 'h0D, 0, 'h05, 'h09, 1, H2,   H2);
      step(1, 0, 'h00, 0, 'h0D, 'h05, 1, H1,   MISS);
      step(1, 0, 'h00, 0, 'h09, 'h04, 1, H2,   H3);
      step(1, 0, 'h00, 0, 'h04, 'h0C, 1, H3,   H1);

      // Reset overrides a concurrent update
      step(0, 1, 'h10, 1, 'h10, 'h04, 0, MISS, MISS);
      step(1, 0, 'h00, 0, 'h10, 'h04, 1, MISS, MISS);
      step(1, 0, 'h00, 0, 'h10, 'h23, 1, MISS, MISS);
      step(1, 1, 'h10, 0, 'h10, 'h23, 1, MISS, MISS);
      step(1, 0, 'h00, 0, 'h10, 'h23, 1, H1,   MISS);

      step(1, 0, 'h00, 0, 'h00, 'h00, 0, MISS, MISS);
      step(1, 0, 'h00, 0, 'h00, 'h00, 0, MISS, MISS);

      n_compared++;
      if (exp_q.size() != 0) begin
         n_failed++;
         $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
